// File: rtl/mem_read_control.sv
// mem_read_control
//   Reads buffered events out of three synchronous memories (event size,
//   L1A number, event data) and streams each one as a framed word sequence:
//   header {2'b10,L1A} (sop), size word, size data words, XOR trailer (eop).
//
// Ports
//   clk, reset (sync, active-low)      clock and reset
//   enable                             start new events when 1
//   es_wr_addr                         last slot written by the write side
//   es_rd_addr / es_rd_data            event-size memory read port
//   L1A_rd_addr / L1A_rd_data          L1A memory read port (same address)
//   data_rd_addr / data_rd_data        event data memory read port
//   dout, dout_valid, dout_ready       output stream with handshake
//   dout_sop, dout_eop                 frame delimiters
//   evt_sent                           completed-frame counter (mod 256)
//   busy                               FSM not idle
//   ovf                                sticky: writer 255 events ahead
module mem_read_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  es_wr_addr,
  output logic [7:0]  es_rd_addr,
  input  logic [10:0] es_rd_data,
  output logic [7:0]  L1A_rd_addr,
  input  logic [13:0] L1A_rd_data,
  output logic [15:0] data_rd_addr,
  input  logic [15:0] data_rd_data,
  output logic [15:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic [7:0]  evt_sent,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, HDR, SIZE, DATA, TRL} state_t;

  state_t      state_reg;
  logic [7:0]  rd_addr_reg;
  logic [15:0] data_addr_reg;
  logic [10:0] size_reg;
  logic [10:0] issued_reg;   // data reads issued for this event
  logic [10:0] loaded_reg;   // data words moved into dout for this event
  logic [15:0] xor_reg;
  logic        pend_reg;     // read address on the bus this cycle
  logic        dv_reg;       // read data valid on data_rd_data this cycle

  // two-entry skid buffer between the data memory and dout
  logic [15:0] skid_mem [2];
  logic        wr_ptr_reg;
  logic        rd_ptr_reg;
  logic [1:0]  skid_cnt_reg;

  logic        fire;
  logic        out_free;
  logic        pending;
  logic        avail;
  logic        load;
  logic        pop;
  logic        push;
  logic        issue;
  logic        fetch_phase;
  logic [2:0]  reserved;
  logic [15:0] load_word;

  assign es_rd_addr   = rd_addr_reg;
  assign L1A_rd_addr  = rd_addr_reg;
  assign data_rd_addr = data_addr_reg;
  assign busy         = (state_reg != IDLE);

  assign fire     = dout_valid & dout_ready;
  assign out_free = ~dout_valid | fire;
  assign pending  = (rd_addr_reg != es_wr_addr);
  assign avail    = (skid_cnt_reg != 2'd0) | dv_reg;

  // Buffered words are older than the word arriving from memory, so they
  // drain first; memory data bypasses the buffer only when it is empty.
  assign load      = (state_reg == DATA) && out_free && avail && (loaded_reg != size_reg);
  assign load_word = (skid_cnt_reg != 2'd0) ? skid_mem[rd_ptr_reg] : data_rd_data;
  assign pop       = load && (skid_cnt_reg != 2'd0);
  assign push      = dv_reg && !(load && (skid_cnt_reg == 2'd0));

  // Every read in flight has a buffer slot reserved for it; a word leaving
  // for dout this cycle frees one. Prefetch already starts in HDR/SIZE so the
  // data phase can stream one word per clock.
  assign reserved    = {1'b0, skid_cnt_reg} + {2'b00, pend_reg} + {2'b00, dv_reg};
  assign fetch_phase = (state_reg == HDR) || (state_reg == SIZE) || (state_reg == DATA);
  assign issue       = fetch_phase && (issued_reg != size_reg) &&
                       (reserved < (3'd2 + {2'b00, load}));

  always_ff @(posedge clk) begin
    if (push) begin
      skid_mem[wr_ptr_reg] <= data_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      skid_cnt_reg <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      skid_cnt_reg <= skid_cnt_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      rd_addr_reg   <= 8'd0;
      data_addr_reg <= 16'd0;
      size_reg      <= 11'd0;
      issued_reg    <= 11'd0;
      loaded_reg    <= 11'd0;
      xor_reg       <= 16'd0;
      pend_reg      <= 1'b0;
      dv_reg        <= 1'b0;
      dout          <= 16'd0;
      dout_valid    <= 1'b0;
      dout_sop      <= 1'b0;
      dout_eop      <= 1'b0;
      evt_sent      <= 8'd0;
      ovf           <= 1'b0;
    end else begin
      if ((es_wr_addr - rd_addr_reg) == 8'd255) ovf <= 1'b1;

      pend_reg <= issue;
      dv_reg   <= pend_reg;
      if (issue) begin
        data_addr_reg <= data_addr_reg + 16'd1;
        issued_reg    <= issued_reg + 11'd1;
      end
      if (load) begin
        loaded_reg <= loaded_reg + 11'd1;
        xor_reg    <= xor_reg ^ load_word;
      end

      case (state_reg)
        IDLE: begin
          // the address moves on entry to FETCH so the memories have it
          // during FETCH and deliver the data during WAIT
          if (enable && pending) begin
            rd_addr_reg <= rd_addr_reg + 8'd1;
            state_reg   <= FETCH;
          end
        end
        FETCH: state_reg <= WAIT;
        WAIT: begin
          size_reg   <= es_rd_data;
          issued_reg <= 11'd0;
          loaded_reg <= 11'd0;
          xor_reg    <= 16'd0;
          dout       <= {2'b10, L1A_rd_data};
          dout_valid <= 1'b1;
          dout_sop   <= 1'b1;
          state_reg  <= HDR;
        end
        HDR: begin
          if (fire) begin
            dout      <= {5'b0, size_reg};
            dout_sop  <= 1'b0;
            state_reg <= SIZE;
          end
        end
        SIZE: begin
          if (fire) begin
            dout <= 16'd0;
            if (size_reg != 11'd0) begin
              dout_valid <= 1'b0;
              state_reg  <= DATA;
            end else begin
              dout_eop  <= 1'b1;
              state_reg <= TRL;
            end
          end
        end
        DATA: begin
          // dout always holds the most recently loaded word, so once all
          // words are loaded a transfer here is the final data word
          if (fire && (loaded_reg == size_reg)) begin
            dout      <= xor_reg;
            dout_eop  <= 1'b1;
            state_reg <= TRL;
          end else if (load) begin
            dout       <= load_word;
            dout_valid <= 1'b1;
          end else if (fire) begin
            dout       <= 16'd0;
            dout_valid <= 1'b0;
          end
        end
        TRL: begin
          if (fire) begin
            dout       <= 16'd0;
            dout_valid <= 1'b0;
            dout_eop   <= 1'b0;
            evt_sent   <= evt_sent + 8'd1;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
